// File: rtl/vector_mem_sequencer_if.sv
// Bundle for vector_mem_sequencer: op request, memory port and vector regfile commit.
// Build macro VSEQ_STRIDE_EN adds the programmable stride signal.
interface vector_mem_sequencer_if #(
  parameter int LANES = 5,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic                  start;
  logic                  is_store;
  logic [AW-1:0]         base_addr;
  logic [3:0]            vd_in;
  logic [LANES*DW-1:0]   vsrc;
`ifdef VSEQ_STRIDE_EN
  logic [AW-1:0]         stride;
`endif
  logic                  mem_req;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic                  mem_ack;
  logic [DW-1:0]         mem_rdata;
  logic                  vec_we;
  logic [3:0]            vec_wa;
  logic [LANES*DW-1:0]   vec_wdata;
  logic                  busy;
  logic                  stall;
  logic                  done;

  // Core and memory side: issues ops, answers memory accesses
  modport master (
`ifdef VSEQ_STRIDE_EN
    output stride,
`endif
    output start, is_store, base_addr, vd_in, vsrc,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  vec_we, vec_wa, vec_wdata, busy, stall, done
  );

  modport slave (
`ifdef VSEQ_STRIDE_EN
    input  stride,
`endif
    input  start, is_store, base_addr, vd_in, vsrc,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output vec_we, vec_wa, vec_wdata, busy, stall, done
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: serialises LANES word accesses over one memory port.
// Build macro VSEQ_STRIDE_EN adds a latched byte stride; otherwise the stride is fixed at 4.
//
// state | meaning
// IDLE  | waiting for start; op fields latched on start
// REQ   | memory access for current lane, held until mem_ack
// FIN   | one-cycle done pulse; loads commit the gathered vector
module vector_mem_sequencer #(
  parameter int LANES = 5,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic                   clk,
  input logic                   reset,
  vector_mem_sequencer_if.slave bus
);

  localparam int            LW        = $clog2(LANES + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic                        store_q, store_d;
  logic [3:0]                  vd_q, vd_d;
  logic [LANES-1:0][DW-1:0]    snap_q, snap_d;
  logic [LANES-1:0][DW-1:0]    lbuf_q, lbuf_d;
  logic [AW-1:0]               step;

  logic                        mem_req;
  logic                        mem_we;
  logic [AW-1:0]               mem_addr;
  logic [DW-1:0]               mem_wdata;
  logic                        vec_we;
  logic                        done;

`ifdef VSEQ_STRIDE_EN
  logic [AW-1:0]               stride_q, stride_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end

  always_comb begin
    stride_d = stride_q;
    if (state_q == IDLE && bus.start) begin
      stride_d = bus.stride;
    end
  end

  assign step = stride_q;
`else
  assign step = AW'(4);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q  <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
      vd_q    <= '0;
      snap_q  <= '0;
      lbuf_q  <= '0;
    end else begin
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      vd_q    <= vd_d;
      snap_q  <= snap_d;
      lbuf_q  <= lbuf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    store_d   = store_q;
    vd_d      = vd_q;
    snap_d    = snap_q;
    lbuf_d    = lbuf_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    vec_we    = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = REQ;
          lane_d  = '0;
          addr_d  = bus.base_addr;
          store_d = bus.is_store;
          vd_d    = bus.vd_in;
          snap_d  = bus.vsrc;
        end
      end

      REQ: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = addr_q;
        mem_wdata = snap_q[lane_q];
        if (bus.mem_ack) begin
          if (!store_q) begin
            lbuf_d[lane_q] = bus.mem_rdata;
          end
          addr_d = addr_q + step;
          // The counter parks on the last lane so it never leaves 0..LANES-1
          if (lane_q == LAST_LANE) begin
            state_d = FIN;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end

      FIN: begin
        done    = 1'b1;
        vec_we  = !store_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.vec_we    = vec_we;
  assign bus.vec_wa    = vd_q;
  assign bus.vec_wdata = lbuf_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.stall     = (state_q != IDLE) | bus.start;
  assign bus.done      = done;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: memory model answers with data = address,
// expected accesses and regfile commits are queued at stimulus time and popped on DUT output.
module tb_vector_mem_sequencer;

  localparam int LANES = 5;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int VW    = LANES * DW;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic [3:0]    vd;
    logic [VW-1:0] data;
  } vec_t;

  logic clk;
  logic rst_n;

  vector_mem_sequencer_if #(.LANES(LANES), .AW(AW), .DW(DW)) bus();

  vector_mem_sequencer #(.LANES(LANES), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  txn_t          txn_q[$];
  vec_t          vec_q[$];
  int            n_err = 0;
  int            n_chk = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            exp_lat = 0;
  int            stall_cnt = 0;
  int            hold_cnt = 0;
  int            stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  logic [AW-1:0] stride_v = 32'd4;
  logic [VW-1:0] cur_vsrc = '0;
  logic [VW-1:0] last_vec = '0;
  bit            done_seen = 1'b0;
  bit            op_active = 1'b0;
  txn_t          mt;
  vec_t          mv;
  bit            ack;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "bench did not finish");
  end

  // Memory model and output monitor, sampled on the falling edge
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      ack = 1'b1;
      if (bus.mem_req && bus.mem_addr == stall_addr && stall_left > 0) begin
        ack = 1'b0;
        stall_left--;
      end
      bus.mem_ack   = ack;
      bus.mem_rdata = bus.mem_addr;
      if (bus.mem_req && bus.mem_addr == stall_addr) hold_cnt++;
      if (op_active && (cyc - start_cyc) <= exp_lat && bus.stall) stall_cnt++;
      if (bus.mem_req && ack) begin
        if (txn_q.size() == 0) begin
          check("unexp_req", VW'(1), VW'(0));
        end else begin
          mt = txn_q.pop_front();
          check("mem_addr", VW'(bus.mem_addr), VW'(mt.addr));
          check("mem_we", VW'(bus.mem_we), VW'(mt.we));
          if (mt.we) check("mem_wdata", VW'(bus.mem_wdata), VW'(mt.wdata));
        end
      end
      if (bus.vec_we) begin
        if (vec_q.size() == 0) begin
          check("unexp_vec_we", VW'(1), VW'(0));
        end else begin
          mv = vec_q.pop_front();
          check("vec_wa", VW'(bus.vec_wa), VW'(mv.vd));
          check("vec_wdata", bus.vec_wdata, mv.data);
          last_vec = mv.data;
        end
      end
      if (bus.done) begin
        if (!op_active) begin
          check("unexp_done", VW'(1), VW'(0));
        end else begin
          done_seen = 1'b1;
          check("done_lat", VW'(cyc - start_cyc), VW'(exp_lat));
        end
      end
    end
  end

  task automatic do_op(input bit st, input logic [AW-1:0] base, input logic [3:0] vd,
                       input int stalls, input int poke, input int abort,
                       input bit chain_in, input bit chain_out);
    txn_t          t;
    vec_t          v;
    logic [AW-1:0] a;
    a      = base;
    v.vd   = vd;
    v.data = '0;
    for (int i = 0; i < LANES; i++) begin
      t.addr  = a;
      t.we    = st;
      t.wdata = cur_vsrc[i*DW +: DW];
      txn_q.push_back(t);
      v.data[i*DW +: DW] = a;
      a = a + stride_v;
    end
    if (!st) vec_q.push_back(v);
    if (!chain_in) begin
      @(posedge clk);
      #1;
    end
    exp_lat    = LANES + 1 + stalls;
    stall_addr = base + 2 * stride_v;
    stall_left = stalls;
    hold_cnt   = 0;
    stall_cnt  = 0;
    done_seen  = 1'b0;
    start_cyc  = cyc;
    op_active  = 1'b1;
    bus.start     = 1'b1;
    bus.is_store  = st;
    bus.base_addr = base;
    bus.vd_in     = vd;
    bus.vsrc      = cur_vsrc;
`ifdef VSEQ_STRIDE_EN
    bus.stride    = stride_v;
`endif
    for (int k = 1; k < 64 && !done_seen; k++) begin
      @(posedge clk);
      #1;
      bus.start = (k == poke);
      if (k == 1) begin
        // Inputs change after start: the op must run on its latched copy
        bus.is_store  = !st;
        bus.base_addr = ~base;
        bus.vd_in     = ~vd;
        bus.vsrc      = ~cur_vsrc;
`ifdef VSEQ_STRIDE_EN
        bus.stride    = stride_v + 32'd8;
`endif
      end
      if (k == abort) begin
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", VW'(bus.mem_req), VW'(0));
        check("rst_busy", VW'(bus.busy), VW'(0));
        check("rst_stall", VW'(bus.stall), VW'(0));
        txn_q.delete();
        vec_q.delete();
        op_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_vec_wdata", bus.vec_wdata, VW'(0));
        return;
      end
    end
    check("done_seen", VW'(done_seen), VW'(1));
    check("stall_cycles", VW'(stall_cnt), VW'(exp_lat + 1));
    check("txn_left", VW'(txn_q.size()), VW'(0));
    check("vec_left", VW'(vec_q.size()), VW'(0));
    if (stalls > 0) check("addr_hold", VW'(hold_cnt), VW'(stalls + 1));
    txn_q.delete();
    vec_q.delete();
    stall_left = 0;
    if (!chain_out) begin
      @(negedge clk);
      check("stall_after", VW'(bus.stall), VW'(0));
      op_active = 1'b0;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_store  = 1'b0;
    bus.base_addr = '0;
    bus.vd_in     = '0;
    bus.vsrc      = '0;
`ifdef VSEQ_STRIDE_EN
    bus.stride    = 32'd4;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", VW'(bus.mem_req), VW'(0));
    check("rst_we", VW'(bus.mem_we), VW'(0));
    check("rst_addr", VW'(bus.mem_addr), VW'(0));
    check("rst_wdata", VW'(bus.mem_wdata), VW'(0));
    check("rst_vec_we", VW'(bus.vec_we), VW'(0));
    check("rst_vec_wa", VW'(bus.vec_wa), VW'(0));
    check("rst_vec_data", bus.vec_wdata, VW'(0));
    check("rst_busy0", VW'(bus.busy), VW'(0));
    check("rst_stall0", VW'(bus.stall), VW'(0));
    check("rst_done", VW'(bus.done), VW'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain load, contiguous
    for (int i = 0; i < LANES; i++) cur_vsrc[i*DW +: DW] = $urandom;
    do_op(1'b0, 32'h0000_0100, 4'd3, 0, 0, 0, 1'b0, 1'b0);

    // Store lanes 1..5; the committed load vector must stay put
    for (int i = 0; i < LANES; i++) cur_vsrc[i*DW +: DW] = DW'(i + 1);
    do_op(1'b1, 32'h0000_0200, 4'd7, 0, 0, 0, 1'b0, 1'b0);
    check("vec_hold", bus.vec_wdata, last_vec);

    // Two ack-low cycles on lane 2
    do_op(1'b0, 32'h0000_0100, 4'd5, 2, 0, 0, 1'b0, 1'b0);

    // Start pulsed in cycle 3 of an active store is ignored
    for (int i = 0; i < LANES; i++) cur_vsrc[i*DW +: DW] = $urandom;
    do_op(1'b1, 32'h0000_0300, 4'd9, 0, 3, 0, 1'b0, 1'b0);

    // Address wrap
    do_op(1'b0, 32'hFFFF_FFF8, 4'd1, 0, 0, 0, 1'b0, 1'b0);

    // Misaligned base passes through
    do_op(1'b0, 32'h0000_0103, 4'd14, 0, 0, 0, 1'b0, 1'b0);

    // Back-to-back: store accepted in the cycle after the load's FIN
    do_op(1'b0, 32'h0000_0400, 4'd2, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < LANES; i++) cur_vsrc[i*DW +: DW] = $urandom;
    do_op(1'b1, 32'h0000_0500, 4'd4, 0, 0, 0, 1'b1, 1'b0);

    // Reset in cycle 3 of a load, then a normal load
    do_op(1'b0, 32'h0000_0600, 4'd6, 0, 0, 3, 1'b0, 1'b0);
    do_op(1'b0, 32'h0000_0700, 4'd8, 1, 0, 0, 1'b0, 1'b0);

`ifdef VSEQ_STRIDE_EN
    stride_v = 32'd0;
    do_op(1'b0, 32'h0000_0800, 4'd10, 0, 0, 0, 1'b0, 1'b0);
    stride_v = 32'd12;
    for (int i = 0; i < LANES; i++) cur_vsrc[i*DW +: DW] = $urandom;
    do_op(1'b1, 32'h0000_0900, 4'd11, 0, 0, 0, 1'b0, 1'b0);
    stride_v = 32'd4;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
